// File: rtl/ifetch_pkg.sv
// Shared definitions for the instruction fetch unit: opcode constants,
// fetch FSM state encodings and the default BHT size.
package ifetch_pkg;

  localparam logic [6:0] CodeJalr = 7'b1100111;
  localparam logic [6:0] CodeBr   = 7'b1100011;
  localparam logic [6:0] CodeJal  = 7'b1101111;

  localparam logic [2:0] ST_IDLE      = 3'd0;
  localparam logic [2:0] ST_FETCH     = 3'd1;
  localparam logic [2:0] ST_HOLD      = 3'd2;
  localparam logic [2:0] ST_JALR_WAIT = 3'd3;
  localparam logic [2:0] ST_DRAIN     = 3'd4;

  localparam int unsigned BHT_INDEX_BIT_DEFAULT = 6;

  function automatic logic is_jalr(input logic [31:0] word);
    return word[6:0] == CodeJalr;
  endfunction

endpackage

// File: rtl/ifetch_bht.sv
// Branch history table: 2^INDEX_BIT two-bit saturating counters.
// Combinational read, synchronous update; a same-cycle read sees the old value.
module ifetch_bht
  import ifetch_pkg::*;
#(
  parameter int unsigned INDEX_BIT = BHT_INDEX_BIT_DEFAULT
) (
  input  logic                 clk_in,
  input  logic                 rst_in,
  input  logic                 rdy_in,
  input  logic [INDEX_BIT-1:0] rd_idx,
  output logic [1:0]           rd_ctr,
  input  logic                 br_valid,
  input  logic [INDEX_BIT-1:0] br_idx,
  input  logic                 br_taken
);

  localparam int unsigned ENTRIES = 1 << INDEX_BIT;

  logic [1:0] ctr_q [ENTRIES];

  assign rd_ctr = ctr_q[rd_idx];

  // Train the addressed counter toward the resolved outcome, saturating at 0/3
  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      ctr_q <= '{default: 2'b01};
    end else if (rdy_in && br_valid) begin
      if (br_taken) begin
        if (ctr_q[br_idx] != 2'b11) ctr_q[br_idx] <= ctr_q[br_idx] + 2'b01;
      end else begin
        if (ctr_q[br_idx] != 2'b00) ctr_q[br_idx] <= ctr_q[br_idx] - 2'b01;
      end
    end
  end

endmodule

// File: rtl/ifetch.sv
// Instruction fetch unit: owns the fetch PC, requests words from the icache,
// presents one instruction at a time to the decoder, stalls on JALR and
// redirects on ROB flush.
// Optional feature macro: BHT_PREDICT_EN (dynamic prediction from a BHT;
// without it predict is constant not-taken and br_* are ignored).
module ifetch
  import ifetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC      = 32'h0,
  parameter int unsigned BHT_INDEX_BIT = BHT_INDEX_BIT_DEFAULT
) (
  input  logic        clk_in,
  input  logic        rst_in,
  input  logic        rdy_in,
  output logic        icache_req,
  output logic [31:0] icache_addr,
  input  logic        icache_valid,
  input  logic [31:0] icache_data,
  output logic        to_decoder,
  output logic [31:0] pc,
  output logic [31:0] inst,
  output logic        predict,
  input  logic [31:0] next_pc,
  input  logic        dec_issued,
  input  logic        jalr_done,
  input  logic [31:0] jalr_target,
  input  logic        flush,
  input  logic [31:0] flush_pc,
  input  logic        br_valid,
  input  logic [31:0] br_pc,
  input  logic        br_taken
);

  logic [2:0]  state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] inst_q, inst_d;
  logic        pred_q, pred_d;
  logic        bht_msb;

`ifdef BHT_PREDICT_EN
  logic [1:0] bht_ctr;
  logic       unused_bht;

  ifetch_bht #(
    .INDEX_BIT (BHT_INDEX_BIT)
  ) u_bht (
    .clk_in   (clk_in),
    .rst_in   (rst_in),
    .rdy_in   (rdy_in),
    .rd_idx   (pc_q[BHT_INDEX_BIT+1:2]),
    .rd_ctr   (bht_ctr),
    .br_valid (br_valid),
    .br_idx   (br_pc[BHT_INDEX_BIT+1:2]),
    .br_taken (br_taken)
  );

  assign bht_msb    = bht_ctr[1];
  assign unused_bht = ^{br_pc[31:BHT_INDEX_BIT+2], br_pc[1:0], bht_ctr[0]};
`else
  logic unused_br;

  assign bht_msb   = 1'b0;
  assign unused_br = ^{br_valid, br_pc, br_taken};
`endif

  assign icache_req  = (state_q == ST_FETCH);
  assign icache_addr = pc_q;
  assign to_decoder  = (state_q == ST_HOLD);
  assign pc          = pc_q;
  assign inst        = inst_q;
  assign predict     = pred_q;

  // Next-state / next-PC selection; flush overrides every other event
  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    inst_d  = inst_q;
    pred_d  = pred_q;
    if (flush) begin
      pc_d = flush_pc;
      // A request still outstanding (FETCH or DRAIN without a response this
      // cycle) must be drained so its data never lands on the new PC.
      if ((state_q == ST_FETCH || state_q == ST_DRAIN) && !icache_valid)
        state_d = ST_DRAIN;
      else
        state_d = ST_FETCH;
    end else begin
      case (state_q)
        ST_IDLE: state_d = ST_FETCH;
        ST_FETCH: begin
          if (icache_valid) begin
            inst_d  = icache_data;
            pred_d  = bht_msb;
            state_d = ST_HOLD;
          end
        end
        ST_HOLD: begin
          if (dec_issued) begin
            if (is_jalr(inst_q)) begin
              state_d = ST_JALR_WAIT;
            end else begin
              pc_d    = next_pc;
              state_d = ST_FETCH;
            end
          end
        end
        ST_JALR_WAIT: begin
          if (jalr_done) begin
            pc_d    = jalr_target;
            state_d = ST_FETCH;
          end
        end
        ST_DRAIN: begin
          if (icache_valid) state_d = ST_FETCH;
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  // Architectural fetch state; everything holds while rdy_in is low
  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      state_q <= ST_IDLE;
      pc_q    <= RESET_PC;
      inst_q  <= '0;
      pred_q  <= 1'b0;
    end else if (rdy_in) begin
      state_q <= state_d;
      pc_q    <= pc_d;
      inst_q  <= inst_d;
      pred_q  <= pred_d;
    end
  end

endmodule

// File: tb/tb_ifetch.sv
// Directed bench for ifetch: a table of per-cycle vectors plus hand-written
// sequences for backpressure, pause, BHT training and async reset.
module tb_ifetch;

  logic        clk_in = 1'b0;
  logic        rst_in;
  logic        rdy_in;
  logic        icache_req;
  logic [31:0] icache_addr;
  logic        icache_valid;
  logic [31:0] icache_data;
  logic        to_decoder;
  logic [31:0] pc;
  logic [31:0] inst;
  logic        predict;
  logic [31:0] next_pc;
  logic        dec_issued;
  logic        jalr_done;
  logic [31:0] jalr_target;
  logic        flush;
  logic [31:0] flush_pc;
  logic        br_valid;
  logic [31:0] br_pc;
  logic        br_taken;

  int unsigned n_tests = 0;
  int unsigned n_fail  = 0;

`ifdef BHT_PREDICT_EN
  localparam logic PRED_TRAINED = 1'b1;
`else
  localparam logic PRED_TRAINED = 1'b0;
`endif

  ifetch #(
    .RESET_PC      (32'h0),
    .BHT_INDEX_BIT (6)
  ) dut (
    .clk_in       (clk_in),
    .rst_in       (rst_in),
    .rdy_in       (rdy_in),
    .icache_req   (icache_req),
    .icache_addr  (icache_addr),
    .icache_valid (icache_valid),
    .icache_data  (icache_data),
    .to_decoder   (to_decoder),
    .pc           (pc),
    .inst         (inst),
    .predict      (predict),
    .next_pc      (next_pc),
    .dec_issued   (dec_issued),
    .jalr_done    (jalr_done),
    .jalr_target  (jalr_target),
    .flush        (flush),
    .flush_pc     (flush_pc),
    .br_valid     (br_valid),
    .br_pc        (br_pc),
    .br_taken     (br_taken)
  );

  always #5 clk_in = ~clk_in;

  typedef struct {
    logic        iv;
    logic [31:0] idata;
    logic        iss;
    logic [31:0] npc;
    logic        jd;
    logic [31:0] jt;
    logic        fl;
    logic [31:0] fpc;
    logic        e_req;
    logic        e_td;
    logic [31:0] e_pc;
    logic [31:0] e_inst;
  } vec_t;

  vec_t vecs[16];

  function automatic vec_t mk(input logic iv, input logic [31:0] idata,
                              input logic iss, input logic [31:0] npc,
                              input logic jd, input logic [31:0] jt,
                              input logic fl, input logic [31:0] fpc,
                              input logic e_req, input logic e_td,
                              input logic [31:0] e_pc, input logic [31:0] e_inst);
    vec_t v;
    v.iv = iv; v.idata = idata; v.iss = iss; v.npc = npc;
    v.jd = jd; v.jt = jt; v.fl = fl; v.fpc = fpc;
    v.e_req = e_req; v.e_td = e_td; v.e_pc = e_pc; v.e_inst = e_inst;
    return v;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic clear_inputs();
    icache_valid = 1'b0; icache_data = '0;
    dec_issued = 1'b0; next_pc = '0;
    jalr_done = 1'b0; jalr_target = '0;
    flush = 1'b0; flush_pc = '0;
    br_valid = 1'b0; br_pc = '0; br_taken = 1'b0;
  endtask

  task automatic step();
    @(posedge clk_in);
    #1;
  endtask

  task automatic check_outs(input string tag, input logic e_req, input logic e_td,
                            input logic [31:0] e_pc, input logic [31:0] e_inst);
    check({tag, ".req"},  {31'b0, icache_req}, {31'b0, e_req});
    check({tag, ".td"},   {31'b0, to_decoder}, {31'b0, e_td});
    check({tag, ".pc"},   pc, e_pc);
    check({tag, ".addr"}, icache_addr, e_pc);
    check({tag, ".inst"}, inst, e_inst);
  endtask

  initial begin
    // Per-cycle vectors: inputs driven for one edge, outputs after that edge.
    //            iv idata         iss npc       jd jt        fl fpc       req td pc        inst
    vecs[0]  = mk(0, 32'h0,        0, 32'h0,   0, 32'h0,   0, 32'h0,   1, 0, 32'h000, 32'h0);
    vecs[1]  = mk(1, 32'h13,       0, 32'h0,   0, 32'h0,   0, 32'h0,   0, 1, 32'h000, 32'h13);
    vecs[2]  = mk(0, 32'h0,        1, 32'h4,   0, 32'h0,   0, 32'h0,   1, 0, 32'h004, 32'h13);
    vecs[3]  = mk(1, 32'h13,       0, 32'h0,   0, 32'h0,   0, 32'h0,   0, 1, 32'h004, 32'h13);
    vecs[4]  = mk(0, 32'h0,        1, 32'h8,   0, 32'h0,   0, 32'h0,   1, 0, 32'h008, 32'h13);
    vecs[5]  = mk(1, 32'h80E7,     0, 32'h0,   0, 32'h0,   0, 32'h0,   0, 1, 32'h008, 32'h80E7);
    vecs[6]  = mk(0, 32'h0,        1, 32'hC,   0, 32'h0,   0, 32'h0,   0, 0, 32'h008, 32'h80E7);
    vecs[7]  = mk(0, 32'h0,        0, 32'h0,   0, 32'h0,   0, 32'h0,   0, 0, 32'h008, 32'h80E7);
    vecs[8]  = mk(0, 32'h0,        0, 32'h0,   1, 32'h100, 0, 32'h0,   1, 0, 32'h100, 32'h80E7);
    vecs[9]  = mk(0, 32'h0,        0, 32'h0,   0, 32'h0,   1, 32'h200, 0, 0, 32'h200, 32'h80E7);
    vecs[10] = mk(0, 32'h0,        0, 32'h0,   0, 32'h0,   0, 32'h0,   0, 0, 32'h200, 32'h80E7);
    vecs[11] = mk(1, 32'hDEADBEEF, 0, 32'h0,   0, 32'h0,   0, 32'h0,   1, 0, 32'h200, 32'h80E7);
    vecs[12] = mk(1, 32'h13,       0, 32'h0,   0, 32'h0,   0, 32'h0,   0, 1, 32'h200, 32'h13);
    vecs[13] = mk(0, 32'h0,        1, 32'h204, 0, 32'h0,   1, 32'h300, 1, 0, 32'h300, 32'h13);
    vecs[14] = mk(1, 32'h55,       0, 32'h0,   0, 32'h0,   1, 32'h400, 1, 0, 32'h400, 32'h13);
    vecs[15] = mk(1, 32'h13,       0, 32'h0,   0, 32'h0,   0, 32'h0,   0, 1, 32'h400, 32'h13);

    rst_in = 1'b0;
    rdy_in = 1'b1;
    clear_inputs();
    step();
    step();
    check_outs("reset", 1'b0, 1'b0, 32'h0, 32'h0);
    check("reset.predict", {31'b0, predict}, 32'h0);
    rst_in = 1'b1;

    for (int i = 0; i < 16; i++) begin
      icache_valid = vecs[i].iv;  icache_data = vecs[i].idata;
      dec_issued   = vecs[i].iss; next_pc     = vecs[i].npc;
      jalr_done    = vecs[i].jd;  jalr_target = vecs[i].jt;
      flush        = vecs[i].fl;  flush_pc    = vecs[i].fpc;
      step();
      check_outs($sformatf("vec%0d", i), vecs[i].e_req, vecs[i].e_td,
                 vecs[i].e_pc, vecs[i].e_inst);
    end
    clear_inputs();
    check("untrained.predict", {31'b0, predict}, 32'h0);

    // Backpressure: five cycles in HOLD without issue
    for (int i = 0; i < 5; i++) begin
      step();
      check_outs($sformatf("bp%0d", i), 1'b0, 1'b1, 32'h400, 32'h13);
    end
    dec_issued = 1'b1; next_pc = 32'h404;
    step();
    clear_inputs();
    check_outs("bp.issue", 1'b1, 1'b0, 32'h404, 32'h13);
    // Request held with a stable address until the response
    for (int i = 0; i < 3; i++) begin
      step();
      check_outs($sformatf("bp.wait%0d", i), 1'b1, 1'b0, 32'h404, 32'h13);
    end
    icache_valid = 1'b1; icache_data = 32'h00100093;
    step();
    clear_inputs();
    check_outs("bp.resp", 1'b0, 1'b1, 32'h404, 32'h00100093);

    // Pause: issue ignored while rdy_in is low
    rdy_in = 1'b0; dec_issued = 1'b1; next_pc = 32'h408;
    step();
    step();
    check_outs("pause", 1'b0, 1'b1, 32'h404, 32'h00100093);
    rdy_in = 1'b1;
    step();
    clear_inputs();
    check_outs("pause.resume", 1'b1, 1'b0, 32'h408, 32'h00100093);
    icache_valid = 1'b1; icache_data = 32'h13;
    step();
    clear_inputs();

    // BHT training toward taken for pc 0x40
    br_valid = 1'b1; br_pc = 32'h40; br_taken = 1'b1;
    step();
    step();
    clear_inputs();
    flush = 1'b1; flush_pc = 32'h40;
    step();
    clear_inputs();
    check_outs("bht.redirect", 1'b1, 1'b0, 32'h40, 32'h13);
    icache_valid = 1'b1; icache_data = 32'h00000063;
    step();
    clear_inputs();
    check("bht.taken.predict", {31'b0, predict}, {31'b0, PRED_TRAINED});
    // Training back toward not-taken; presented prediction stays latched
    br_valid = 1'b1; br_pc = 32'h40; br_taken = 1'b0;
    step();
    step();
    clear_inputs();
    check("bht.latched.predict", {31'b0, predict}, {31'b0, PRED_TRAINED});
    flush = 1'b1; flush_pc = 32'h40;
    step();
    clear_inputs();
    icache_valid = 1'b1; icache_data = 32'h00000063;
    step();
    clear_inputs();
    check("bht.nottaken.predict", {31'b0, predict}, 32'h0);
    check("bht.nottaken.td", {31'b0, to_decoder}, 32'h1);

    // Asynchronous reset mid-cycle while in HOLD
    @(posedge clk_in);
    #3;
    rst_in = 1'b0;
    #1;
    check_outs("areset", 1'b0, 1'b0, 32'h0, 32'h0);
    check("areset.predict", {31'b0, predict}, 32'h0);
    step();
    rst_in = 1'b1;
    step();
    check_outs("areset.restart", 1'b1, 1'b0, 32'h0, 32'h0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
